// File: rtl/mainfsm_pkg.sv
// Shared encodings for the multicycle ARM control path: FSM states, instruction
// op classes and the datapath mux selects that decode and the datapath also use.
package mainfsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_UNKNOWN  = 4'd10
  } state_e;

  localparam logic [1:0] OP_DP     = 2'b00;
  localparam logic [1:0] OP_MEM    = 2'b01;
  localparam logic [1:0] OP_BRANCH = 2'b10;

  localparam logic [1:0] SRCA_REG    = 2'b00;
  localparam logic [1:0] SRCA_PC     = 2'b01;
  localparam logic [1:0] SRCA_ALUOUT = 2'b10;

  localparam logic [1:0] SRCB_WDATA = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  typedef struct packed {
    logic       irWrite;
    logic       adrSrc;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] resultSrc;
    logic       nextPC;
    logic       regW;
    logic       memW;
    logic       branch;
    logic       aluOp;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/mainfsm_if.sv
// Decode <-> main FSM bundle. No handshake: decode holds Op/Funct stable from the
// end of FETCH, and every control output is a level decoded from the current state.
interface mainfsm_if #(
  parameter int STATE_W = 4
);
  logic [1:0]         Op;
  logic [5:0]         Funct;
  logic               IRWrite;
  logic               AdrSrc;
  logic [1:0]         ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         ResultSrc;
  logic               NextPC;
  logic               RegW;
  logic               MemW;
  logic               Branch;
  logic               ALUOp;
  logic               Illegal;
  logic [STATE_W-1:0] State;

  modport master (
    output Op, Funct,
    input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC,
    input  RegW, MemW, Branch, ALUOp, Illegal, State
  );

  modport slave (
    input  Op, Funct,
    output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC,
    output RegW, MemW, Branch, ALUOp, Illegal, State
  );
endinterface

// File: rtl/mainfsm_outdec.sv
// Moore output table: registered state -> datapath selects and raw strobes.
// Any encoding outside the defined states decodes like UNKNOWN so nothing goes X.
module mainfsm_outdec
  import mainfsm_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic [STATE_W-1:0] state,
  output ctrl_t              ctrl
);

  state_e cur;

  always_comb begin
    cur = S_UNKNOWN;
    if (state <= STATE_W'(S_UNKNOWN)) cur = state_e'(state[3:0]);
  end

  always_comb begin
    ctrl = CTRL_IDLE;
    case (cur)
      S_FETCH: begin
        ctrl.irWrite   = 1'b1;
        ctrl.nextPC    = 1'b1;
        ctrl.aluSrcA   = SRCA_PC;
        ctrl.aluSrcB   = SRCB_FOUR;
        ctrl.resultSrc = RES_ALU;
      end
      S_DECODE: begin
        // PC+8 is formed here so R15 reads correctly during register fetch
        ctrl.aluSrcA   = SRCA_PC;
        ctrl.aluSrcB   = SRCB_FOUR;
        ctrl.resultSrc = RES_ALU;
      end
      S_MEMADR: begin
        ctrl.aluSrcA = SRCA_REG;
        ctrl.aluSrcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        ctrl.adrSrc    = 1'b1;
        ctrl.resultSrc = RES_ALUOUT;
      end
      S_MEMWB: begin
        ctrl.resultSrc = RES_DATA;
        ctrl.regW      = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.adrSrc    = 1'b1;
        ctrl.resultSrc = RES_ALUOUT;
        ctrl.memW      = 1'b1;
      end
      S_EXECUTER: begin
        ctrl.aluSrcA = SRCA_REG;
        ctrl.aluSrcB = SRCB_WDATA;
        ctrl.aluOp   = 1'b1;
      end
      S_EXECUTEI: begin
        ctrl.aluSrcA = SRCA_REG;
        ctrl.aluSrcB = SRCB_IMM;
        ctrl.aluOp   = 1'b1;
      end
      S_ALUWB: begin
        ctrl.resultSrc = RES_ALUOUT;
        ctrl.regW      = 1'b1;
      end
      S_BRANCH: begin
        ctrl.aluSrcA   = SRCA_REG;
        ctrl.aluSrcB   = SRCB_IMM;
        ctrl.resultSrc = RES_ALU;
        ctrl.branch    = 1'b1;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mainfsm.sv
// Main control FSM of the multicycle ARM core: state register plus next-state logic.
// STATE_W must be at least 4; outputs come from mainfsm_outdec and depend only on state.
module mainfsm
  import mainfsm_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  mainfsm_if.slave   bus
);

  logic [STATE_W-1:0] stateQ;
  logic [STATE_W-1:0] stateD;
  state_e             cur;
  state_e             nxt;
  ctrl_t              ctrl;
  logic               unusedFunct;

  // Only I (bit 5) and L/S (bit 0) steer the sequence.
  assign unusedFunct = ^bus.Funct[4:1];

  always_ff @(posedge clk) begin
    if (reset) stateQ <= STATE_W'(S_FETCH);
    else       stateQ <= stateD;
  end

  always_comb begin
    cur = S_UNKNOWN;
    if (stateQ <= STATE_W'(S_UNKNOWN)) cur = state_e'(stateQ[3:0]);
  end

  always_comb begin
    nxt = S_UNKNOWN;
    case (cur)
      S_FETCH: nxt = S_DECODE;
      S_DECODE: begin
        case (bus.Op)
          OP_DP:     nxt = bus.Funct[5] ? S_EXECUTEI : S_EXECUTER;
          OP_MEM:    nxt = S_MEMADR;
          OP_BRANCH: nxt = S_BRANCH;
          default:   nxt = S_UNKNOWN;
        endcase
      end
      S_MEMADR:   nxt = bus.Funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  nxt = S_MEMWB;
      S_MEMWB:    nxt = S_FETCH;
      S_MEMWRITE: nxt = S_FETCH;
      S_EXECUTER: nxt = S_ALUWB;
      S_EXECUTEI: nxt = S_ALUWB;
      S_ALUWB:    nxt = S_FETCH;
      S_BRANCH:   nxt = S_FETCH;
      default:    nxt = S_UNKNOWN;
    endcase
    stateD = STATE_W'(nxt);
  end

  mainfsm_outdec #(.STATE_W(STATE_W)) u_outdec (
    .state (stateQ),
    .ctrl  (ctrl)
  );

  assign bus.IRWrite   = ctrl.irWrite;
  assign bus.AdrSrc    = ctrl.adrSrc;
  assign bus.ALUSrcA   = ctrl.aluSrcA;
  assign bus.ALUSrcB   = ctrl.aluSrcB;
  assign bus.ResultSrc = ctrl.resultSrc;
  assign bus.NextPC    = ctrl.nextPC;
  assign bus.RegW      = ctrl.regW;
  assign bus.MemW      = ctrl.memW;
  assign bus.Branch    = ctrl.branch;
  assign bus.ALUOp     = ctrl.aluOp;
  assign bus.Illegal   = ctrl.illegal;
  assign bus.State     = stateQ;

endmodule
